// File: rtl/reaction_timer_multi_pkg.sv
// Shared types for the multi-player reaction timer: FSM states and
// per-player status codes as they appear on player_status.
package reaction_timer_multi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_RAND,
    S_RETRY,
    S_RAND_WAIT,
    S_REACT,
    S_RESULT
  } state_t;

  typedef enum logic [1:0] {
    PS_WAIT    = 2'd0,
    PS_VALID   = 2'd1,
    PS_EARLY   = 2'd2,
    PS_TIMEOUT = 2'd3
  } pstat_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_MS_COUNT clocks.
// clr restarts the count so the first tick lands a full period later.
module ms_tick_gen #(
  parameter int CLK_MS_COUNT = 100_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_MS_COUNT > 1) ? $clog2(CLK_MS_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_MS_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // next count: clear wins, otherwise wrap at the last value
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  // prescaler register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// N-player reaction timer: random delay, shared LED cue, per-player stop
// with false-start and timeout detection, winner and session-best tracking.
module reaction_timer_multi
  import reaction_timer_multi_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int CLK_MS_COUNT = 100_000,
  parameter int TIME_W       = 14,
  parameter int REACTION_MAX = 1_000,
  parameter int RAND_MIN     = 2_000,
  parameter int RAND_MAX     = 15_000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          clear,
  input  logic [N_PLAYERS-1:0]          stop,
  input  logic                          rand_done,
  input  logic [TIME_W-1:0]             rand_num,
  output logic                          rand_start,
  output logic [N_PLAYERS*TIME_W-1:0]   reaction_time,
  output logic [2*N_PLAYERS-1:0]        player_status,
  output logic                          winner_valid,
  output logic [((N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1)-1:0] winner_id,
  output logic [TIME_W-1:0]             best_time,
  output logic                          reaction_led,
  output logic                          sseg_active,
  output logic                          sseg_mesg,
  output logic                          bcd_start
);

  localparam int WID_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [TIME_W-1:0] T_TIMEOUT = TIME_W'(REACTION_MAX + 1);
  localparam logic [TIME_W-1:0] R_MIN     = TIME_W'(RAND_MIN);
  localparam logic [TIME_W-1:0] R_MAX     = TIME_W'(RAND_MAX);

  state_t state_q, state_d;
  logic [N_PLAYERS-1:0][1:0]        st_q, st_d;
  logic [N_PLAYERS-1:0][TIME_W-1:0] tm_q, tm_d;
  logic [TIME_W-1:0] ms_q, ms_d, ms_inc, delay_q, delay_d, best_q, best_d;
  logic entry_q, entry_d, rand_start_q, rand_start_d, bcd_start_q, bcd_start_d;
  logic tick, tick_clr, rand_ok, at_delay, at_timeout, any_wait, all_early;
  logic win_found;
  logic [WID_W-1:0]  win_idx;
  logic [TIME_W-1:0] win_time;

  ms_tick_gen #(.CLK_MS_COUNT(CLK_MS_COUNT)) u_tick (
    .clk(clk), .reset_n(reset_n), .clr(tick_clr), .tick(tick)
  );

  assign ms_inc     = ms_q + TIME_W'(1);
  assign rand_ok    = (rand_num >= R_MIN) && (rand_num <= R_MAX);
  assign at_delay   = tick && (ms_inc == delay_q);
  assign at_timeout = (ms_q == T_TIMEOUT);

  // per-player status/time update; clear suppresses any update in its cycle
  always_comb begin
    st_d = st_q;
    tm_d = tm_q;
    case (state_q)
      S_IDLE: if (start) begin
        st_d = '0;
        tm_d = '0;
      end
      S_RAND_WAIT: if (!clear) begin
        for (int i = 0; i < N_PLAYERS; i++)
          if (stop[i] && st_q[i] == PS_WAIT) st_d[i] = PS_EARLY;
      end
      S_REACT: if (!clear) begin
        for (int i = 0; i < N_PLAYERS; i++)
          if (st_q[i] == PS_WAIT) begin
            if (at_timeout) st_d[i] = PS_TIMEOUT;
            else if (stop[i]) begin
              st_d[i] = PS_VALID;
              tm_d[i] = ms_q;
            end
          end
      end
      default: ;
    endcase
    any_wait  = 1'b0;
    all_early = 1'b1;
    for (int i = 0; i < N_PLAYERS; i++) begin
      any_wait  = any_wait  | (st_d[i] == PS_WAIT);
      all_early = all_early & (st_d[i] == PS_EARLY);
    end
  end

  // fastest VALID player; strict compare keeps the lowest index on a tie
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_time  = '1;
    for (int i = 0; i < N_PLAYERS; i++)
      if (st_q[i] == PS_VALID && (!win_found || tm_q[i] < win_time)) begin
        win_found = 1'b1;
        win_idx   = WID_W'(i);
        win_time  = tm_q[i];
      end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_GET_RAND;
      S_GET_RAND:  if (rand_done) state_d = rand_ok ? S_RAND_WAIT : S_RETRY;
      S_RETRY:     state_d = S_GET_RAND;
      S_RAND_WAIT: if (clear) state_d = S_IDLE;
                   else if (all_early) state_d = S_RESULT;
                   else if (at_delay) state_d = S_REACT;
      S_REACT:     if (clear) state_d = S_IDLE;
                   else if (!any_wait) state_d = S_RESULT;
      S_RESULT:    if (clear) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // delay latch, ms counter (restarted on entry to each timed phase), best time
  always_comb begin
    delay_d  = delay_q;
    ms_d     = ms_q;
    best_d   = best_q;
    tick_clr = (state_d != state_q) &&
               (state_d == S_RAND_WAIT || state_d == S_REACT);
    entry_d  = (state_d == S_RESULT) && (state_q != S_RESULT);
    if (state_q == S_GET_RAND && rand_done && rand_ok) delay_d = rand_num;
    if (tick_clr) ms_d = '0;
    else if (tick && state_d == state_q &&
             (state_q == S_RAND_WAIT || state_q == S_REACT)) ms_d = ms_inc;
    if (entry_q && win_found && win_time < best_q) best_d = win_time;
  end

  // output decode; request pulses are registered so reset cannot glitch them
  always_comb begin
    rand_start_d = (state_q == S_IDLE && start) || (state_q == S_RETRY);
    bcd_start_d  = entry_d || (state_q == S_REACT && state_d == S_REACT && tick);
    winner_valid = (state_q == S_RESULT) && win_found;
    winner_id    = winner_valid ? win_idx : '0;
    reaction_led = (state_q == S_REACT) || winner_valid;
    sseg_active  = (state_q == S_IDLE) || (state_q == S_REACT) ||
                   (state_q == S_RESULT);
    sseg_mesg    = (state_q == S_IDLE);
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      st_q         <= '0;
      tm_q         <= '0;
      ms_q         <= '0;
      delay_q      <= '0;
      best_q       <= '1;
      entry_q      <= 1'b0;
      rand_start_q <= 1'b0;
      bcd_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      st_q         <= st_d;
      tm_q         <= tm_d;
      ms_q         <= ms_d;
      delay_q      <= delay_d;
      best_q       <= best_d;
      entry_q      <= entry_d;
      rand_start_q <= rand_start_d;
      bcd_start_q  <= bcd_start_d;
    end
  end

  assign rand_start    = rand_start_q;
  assign bcd_start     = bcd_start_q;
  assign reaction_time = tm_q;
  assign player_status = st_q;
  assign best_time     = best_q;

endmodule
